// File: rtl/router_pkt_ctrl.sv
// router_pkt_ctrl: packet-sequencing Moore FSM for the 1x3 router input path.
// Define ROUTER_CTRL_TIMEOUT_EN to build the WTE/FFS stall timeout.
module router_pkt_ctrl #(
    parameter int TIMEOUT_CYCLES = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       packet_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_packet_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy,
    output logic       timeout_abort,
    output logic [1:0] timeout_dest
);

    typedef enum logic [2:0] {
        DA  = 3'd0,
        WTE = 3'd1,
        LFD = 3'd2,
        LD  = 3'd3,
        FFS = 3'd4,
        LAF = 3'd5,
        LP  = 3'd6,
        CPE = 3'd7
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] addr;
    logic [2:0] empty_vec;
    logic [2:0] soft_vec;
    logic       header_ok;
    logic       soft_hit;
    logic       stall_expired;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..255");
    end

    assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_vec  = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign header_ok = packet_valid && (data_in != 2'd3);
    // Soft reset is only meaningful once a destination has been latched.
    assign soft_hit  = (state != DA) && soft_vec[addr];

`ifdef ROUTER_CTRL_TIMEOUT_EN
    localparam logic [7:0] STALL_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] stall_cnt;
    logic       stall_hold;
    logic       abort_next;

    always_comb begin
        stall_hold    = ((state == WTE) && !empty_vec[addr]) ||
                        ((state == FFS) && fifo_full);
        stall_expired = stall_hold && (stall_cnt == STALL_LAST);
        abort_next    = stall_expired && !soft_hit;
    end

    // Counts cycles already spent in the current stall; zero on stall entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_hold && !stall_expired && !soft_hit) begin
            stall_cnt <= stall_cnt + 8'd1;
        end else begin
            stall_cnt <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_abort <= 1'b0;
            timeout_dest  <= 2'd0;
        end else begin
            timeout_abort <= abort_next;
            if (abort_next) begin
                timeout_dest <= addr;
            end
        end
    end
`else
    assign stall_expired = 1'b0;
    assign timeout_abort = 1'b0;
    assign timeout_dest  = 2'd0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DA;
            addr  <= 2'd0;
        end else begin
            state <= next_state;
            if ((state == DA) && header_ok) begin
                addr <= data_in;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            DA:  if (header_ok) next_state = empty_vec[data_in] ? LFD : WTE;
            WTE: if (empty_vec[addr]) next_state = LFD;
            LFD: next_state = LD;
            LD: begin
                if (fifo_full)          next_state = FFS;
                else if (!packet_valid) next_state = LP;
            end
            FFS: if (!fifo_full) next_state = LAF;
            LAF: begin
                if (parity_done)           next_state = DA;
                else if (low_packet_valid) next_state = LP;
                else                       next_state = LD;
            end
            LP:  next_state = CPE;
            CPE: next_state = fifo_full ? FFS : DA;
            default: next_state = DA;
        endcase
        if (stall_expired) next_state = DA;
        if (soft_hit)      next_state = DA;
    end

    // busy is the source hold-off: while high the source keeps presenting its byte.
    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b0;
        case (state)
            DA:  detect_add = 1'b1;
            WTE: busy = 1'b1;
            LFD: begin
                lfd_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            LD: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            FFS: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LAF: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            LP: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            CPE: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            default: detect_add = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// tb_router_pkt_ctrl: directed test-plan steps plus random traffic against a phase-level model.
// Timeout steps are built only when ROUTER_CTRL_TIMEOUT_EN is defined.
module tb_router_pkt_ctrl;

    localparam int TO = 30;

    logic       clock = 1'b0;
    logic       reset;
    logic       packet_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_packet_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy, timeout_abort;
    logic [1:0] timeout_dest;

    int checks = 0;
    int fails  = 0;

    router_pkt_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clock            (clock),
        .reset            (reset),
        .packet_valid     (packet_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .fifo_empty_0     (fifo_empty_0),
        .fifo_empty_1     (fifo_empty_1),
        .fifo_empty_2     (fifo_empty_2),
        .soft_reset_0     (soft_reset_0),
        .soft_reset_1     (soft_reset_1),
        .soft_reset_2     (soft_reset_2),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .write_enb_reg    (write_enb_reg),
        .rst_int_reg      (rst_int_reg),
        .busy             (busy),
        .timeout_abort    (timeout_abort),
        .timeout_dest     (timeout_dest)
    );

    always #5 clock = ~clock;

    // Reference model: packet phase, latched destination, time spent in the current phase.
    typedef enum {M_DA, M_WTE, M_LFD, M_LD, M_FFS, M_LAF, M_LP, M_CPE} m_ph_t;
    m_ph_t      m_ph = M_DA;
    logic [1:0] m_addr = 2'd0;
    int         m_age = 0;
    logic       m_abort = 1'b0;
    logic [1:0] m_tdest = 2'd0;

    int n_wenb, n_rst, n_wte, n_ffs, n_ffs_wenb, n_da;

    // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy} for each phase
    function automatic logic [7:0] exp_outs(input m_ph_t p);
        case (p)
            M_DA:    return 8'b1000_0000;
            M_WTE:   return 8'b0000_0001;
            M_LFD:   return 8'b0100_0101;
            M_LD:    return 8'b0010_0100;
            M_FFS:   return 8'b0000_1001;
            M_LAF:   return 8'b0001_0101;
            M_LP:    return 8'b0000_0101;
            default: return 8'b0000_0011;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        m_ph_t      nx;
        logic       ab;
        logic [2:0] emp;
        logic [2:0] srst;
        emp  = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
        srst = {soft_reset_2, soft_reset_1, soft_reset_0};
        if (reset) begin
            m_ph = M_DA; m_addr = 2'd0; m_age = 0; m_abort = 1'b0; m_tdest = 2'd0;
            return;
        end
        nx = m_ph;
        ab = 1'b0;
        case (m_ph)
            M_DA:  if (packet_valid && data_in != 2'd3) nx = emp[data_in] ? M_LFD : M_WTE;
            M_WTE: if (emp[m_addr]) nx = M_LFD;
            M_LFD: nx = M_LD;
            M_LD:  nx = fifo_full ? M_FFS : (!packet_valid ? M_LP : M_LD);
            M_FFS: if (!fifo_full) nx = M_LAF;
            M_LAF: nx = parity_done ? M_DA : (low_packet_valid ? M_LP : M_LD);
            M_LP:  nx = M_CPE;
            default: nx = fifo_full ? M_FFS : M_DA;
        endcase
`ifdef ROUTER_CTRL_TIMEOUT_EN
        if ((m_ph == M_WTE || m_ph == M_FFS) && nx == m_ph && m_age + 1 == TO) begin
            nx = M_DA;
            ab = 1'b1;
        end
`endif
        if (m_ph != M_DA && srst[m_addr]) begin
            nx = M_DA;
            ab = 1'b0;
        end
        if (ab) m_tdest = m_addr;
        m_abort = ab;
        if (m_ph == M_DA && packet_valid && data_in != 2'd3) m_addr = data_in;
        m_age = (nx == m_ph) ? m_age + 1 : 0;
        m_ph  = nx;
    endtask

    task automatic clear_tally();
        n_wenb = 0; n_rst = 0; n_wte = 0; n_ffs = 0; n_ffs_wenb = 0; n_da = 0;
    endtask

    // One clock: advance the model on the sampled inputs, then compare just after the edge.
    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check("outs", {8'd0, detect_add, lfd_state, ld_state, laf_state, full_state,
                       write_enb_reg, rst_int_reg, busy}, {8'd0, exp_outs(m_ph)});
        check("abort", {15'd0, timeout_abort}, {15'd0, m_abort});
        if (m_abort) check("tdest", {14'd0, timeout_dest}, {14'd0, m_tdest});
        n_wenb     += int'(write_enb_reg);
        n_rst      += int'(rst_int_reg);
        n_ffs      += int'(full_state);
        n_ffs_wenb += int'(full_state && write_enb_reg);
        n_da       += int'(detect_add);
        n_wte      += int'(busy && !lfd_state && !laf_state && !full_state &&
                           !write_enb_reg && !rst_int_reg);
    endtask

    task automatic idle_inputs();
        packet_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_packet_valid = 1'b0;
    endtask

    initial begin
        int k;
        idle_inputs();
        clear_tally();
        reset = 1'b1;
        cycle();
        cycle();
        check("reset_detect_add", {15'd0, detect_add}, 16'd1);
        check("reset_busy", {15'd0, busy}, 16'd0);
        reset = 1'b0;
        cycle();

        // Destination 1, three payload bytes, then parity.
        clear_tally();
        packet_valid = 1'b1; data_in = 2'd1;
        cycle();
        cycle();
        cycle();
        cycle();
        packet_valid = 1'b0;
        cycle();
        cycle();
        cycle();
        check("t1_wenb_cycles", 16'(n_wenb), 16'd5);
        check("t1_rst_int_cycles", 16'(n_rst), 16'd1);
        check("t1_back_in_da", {15'd0, detect_add}, 16'd1);

        // Destination 2 not empty for four samples.
        clear_tally();
        fifo_empty_2 = 1'b0; packet_valid = 1'b1; data_in = 2'd2;
        cycle();
        cycle();
        cycle();
        cycle();
        fifo_empty_2 = 1'b1;
        cycle();
        check("t2_wte_cycles", 16'(n_wte), 16'd4);
        check("t2_lfd_after_empty", {15'd0, lfd_state}, 16'd1);
        cycle();
        packet_valid = 1'b0;
        cycle();
        cycle();
        cycle();

        // FIFO full for three cycles during the second payload byte.
        clear_tally();
        packet_valid = 1'b1; data_in = 2'd0;
        cycle();
        cycle();
        fifo_full = 1'b1;
        cycle();
        cycle();
        cycle();
        fifo_full = 1'b0;
        cycle();
        check("t3_laf", {15'd0, laf_state}, 16'd1);
        cycle();
        check("t3_back_to_ld", {15'd0, ld_state}, 16'd1);
        check("t3_ffs_cycles", 16'(n_ffs), 16'd3);
        check("t3_ffs_no_write", 16'(n_ffs_wenb), 16'd0);
        packet_valid = 1'b0;
        cycle();
        cycle();
        cycle();

        // Illegal header address.
        clear_tally();
        packet_valid = 1'b1; data_in = 2'd3;
        cycle();
        cycle();
        cycle();
        check("t4_stays_da", 16'(n_da), 16'd3);
        check("t4_no_write", 16'(n_wenb), 16'd0);
        packet_valid = 1'b0;

        // Soft reset of the selected destination aborts; another destination's does not.
        packet_valid = 1'b1; data_in = 2'd0;
        cycle();
        cycle();
        soft_reset_0 = 1'b1;
        packet_valid = 1'b0;
        cycle();
        soft_reset_0 = 1'b0;
        check("t5_soft_reset_da", {15'd0, detect_add}, 16'd1);
        packet_valid = 1'b1;
        cycle();
        cycle();
        soft_reset_1 = 1'b1;
        cycle();
        soft_reset_1 = 1'b0;
        check("t5_other_soft_reset", {15'd0, ld_state}, 16'd1);
        packet_valid = 1'b0;
        cycle();
        cycle();
        cycle();

`ifdef ROUTER_CTRL_TIMEOUT_EN
        // Destination 1 never empties: abort after TO cycles in WTE.
        fifo_empty_1 = 1'b0; packet_valid = 1'b1; data_in = 2'd1;
        cycle();
        packet_valid = 1'b0;
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            cycle();
            if (detect_add) begin
                k = i;
                break;
            end
        end
        check("t6_timeout_cycle", 16'(k), 16'(TO));
        check("t6_abort_pulse", {15'd0, timeout_abort}, 16'd1);
        check("t6_abort_dest", {14'd0, timeout_dest}, 16'd1);
        cycle();
        check("t6_abort_one_cycle", {15'd0, timeout_abort}, 16'd0);
        fifo_empty_1 = 1'b1;
`endif

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 2000; i++) begin
            reset            = ($urandom_range(199, 0) == 0);
            packet_valid     = ($urandom_range(99, 0) < 80);
            data_in          = 2'($urandom_range(3, 0));
            fifo_full        = ($urandom_range(99, 0) < 15);
            fifo_empty_0     = ($urandom_range(99, 0) < 70);
            fifo_empty_1     = ($urandom_range(99, 0) < 70);
            fifo_empty_2     = ($urandom_range(99, 0) < 70);
            soft_reset_0     = ($urandom_range(99, 0) < 3);
            soft_reset_1     = ($urandom_range(99, 0) < 3);
            soft_reset_2     = ($urandom_range(99, 0) < 3);
            parity_done      = ($urandom_range(99, 0) < 20);
            low_packet_valid = ($urandom_range(99, 0) < 20);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/router_pkt_ctrl.md
# router_pkt_ctrl

Packet-sequencing controller for the 1x3 router input path. Decodes the header address, waits for the destination FIFO to drain, and steps the byte register/parity block through header, payload, FIFO-full stall, parity and error-check phases. It drives the register block's phase strobes and the FIFO write enable, and raises `busy` to hold off the source. It sits between the input port, the FIFO synchronizer and the byte register block.

## Interface
- `TIMEOUT_CYCLES`, default 30: stall limit in cycles, used only with the timeout feature; legal range 2..255.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `packet_valid` in 1: source byte valid; high for header and payload, low on the parity byte.
- `data_in` in 2: header address bits [1:0]; 3 is illegal.
- `fifo_full` in 1: full flag of the currently selected destination FIFO, muxed by the synchronizer.
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2` in 1 each: per-destination empty flags.
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2` in 1 each: per-destination soft reset.
- `parity_done` in 1: parity byte captured (from register block).
- `low_packet_valid` in 1: end of packet seen (from register block).
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state` out 1 each: phase strobes.
- `write_enb_reg` out 1: FIFO write enable.
- `rst_int_reg` out 1: clears `low_packet_valid` in the register block.
- `busy` out 1: source must hold its current byte.
- `timeout_abort` out 1: one-cycle pulse when a stall times out.
- `timeout_dest` out 2: destination index of the aborted packet.

## Operation
- Moore FSM; all outputs are a combinational decode of the state register, except `timeout_abort` and `timeout_dest`, which are registered.
- A 2-bit `addr` register captures `data_in` when DA exits with a legal header.
- States, with the outputs asserted in each:
  - DA (decode address), asserts `detect_add`:
    - `packet_valid` and `data_in` not 3, selected `fifo_empty` = 1 -> LFD.
    - `packet_valid` and `data_in` not 3, selected `fifo_empty` = 0 -> WTE.
    - Otherwise stay in DA.
  - WTE (wait till empty), asserts `busy`: -> LFD when `fifo_empty[addr]` = 1.
  - LFD (load first data), asserts `lfd_state`, `busy`, `write_enb_reg`: -> LD unconditionally.
  - LD (load data), asserts `ld_state`, `write_enb_reg`; `busy` = 0:
    - `fifo_full` -> FFS (takes priority).
    - Else `!packet_valid` -> LP.
    - Else stay in LD.
  - FFS (FIFO full), asserts `full_state`, `busy`: -> LAF when `fifo_full` = 0.
  - LAF (load after full), asserts `laf_state`, `busy`, `write_enb_reg`:
    - `parity_done` -> DA.
    - `low_packet_valid` -> LP.
    - Else -> LD.
  - LP (load parity), asserts `busy`, `write_enb_reg`: -> CPE.
  - CPE (check parity error), asserts `rst_int_reg`, `busy`:
    - `fifo_full` -> FFS.
    - Else -> DA.
- Soft reset: `soft_reset[addr]` high in any state other than DA forces the next state to DA. It overrides every transition, including the timeout.
- Reset: state = DA and `addr` = 0.
  - Outputs during and after reset: `detect_add` = 1; all other outputs 0.
  - `timeout_abort` = 0, `timeout_dest` = 0.

## Timing
- All transitions take effect on the rising edge after their condition is sampled; no combinational input-to-output paths.
- Header to first write:
  - Header in DA at cycle 0 -> LFD at cycle 1 (`write_enb_reg` = 1) -> LD at cycle 2.
  - If the destination is busy, the packet spends one or more cycles in WTE before LFD.
- Parity byte: `packet_valid` falls in LD at cycle n -> LP at n+1 -> CPE at n+2 -> DA at n+3.
- `busy` is 0 only in DA and LD.
- `fifo_full` and `!packet_valid` sampled together in LD -> FFS; the parity phase is resumed via LAF.
- A header with address 3 leaves the FSM in DA; `addr` is not updated.

## Configuration
- `ROUTER_CTRL_TIMEOUT_EN` defined:
  - An 8-bit stall counter clears on entry to WTE or FFS and increments each cycle the state is held.
  - If the counter equals `TIMEOUT_CYCLES`-1 and the exit condition is still false, the next state is DA.
  - On that edge `timeout_abort` = 1 for exactly one cycle and `timeout_dest` = `addr`.
  - Result: entering a stall at cycle 0 puts the FSM in DA at cycle `TIMEOUT_CYCLES`.
- `ROUTER_CTRL_TIMEOUT_EN` undefined:
  - No counter is built; stalls are unbounded.
  - `timeout_abort` and `timeout_dest` are tied to 0.

## Test plan
- Destination 1 empty; header 0x01, 3 payload bytes, then parity -> state sequence DA, LFD, LD x3, LP, CPE, DA; `write_enb_reg` high for 5 cycles; `rst_int_reg` high 1 cycle.
- Header to destination 2 with `fifo_empty_2` = 0 for 4 cycles -> `busy` high for 4 cycles in WTE, then LFD on the cycle after `fifo_empty_2` rises.
- `fifo_full` = 1 for 3 cycles during the 2nd payload byte -> FFS for 3 cycles with `write_enb_reg` = 0, then LAF, then LD; no byte is lost.
- Header `data_in` = 3 with `packet_valid` = 1 -> remains in DA, `detect_add` stays 1, `write_enb_reg` stays 0.
- `soft_reset_0` pulsed while in LD for destination 0 -> DA next cycle; `soft_reset_1` pulsed in the same situation -> no effect.
- With `ROUTER_CTRL_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 30, destination 1 never empties -> DA at cycle 30, `timeout_abort` = 1 for one cycle, `timeout_dest` = 1.
